// File: rtl/mnist_layer_sequencer.sv
// Sequences the shared MAC through every layer-1 neuron, then every layer-2 neuron, with a running argmax.
// Latency: 1 + sum over neurons of (1 clear + FANIN issue + stall + result latency + 1 next) cycles from start to done.
// Backpressure: an operand issue holds while dp_ready is low; result latency is unbounded (waits on res_valid).
module mnist_layer_sequencer #(
  parameter int L1_IN  = 784,
  parameter int L1_OUT = 32,
  parameter int L2_OUT = 10,
  parameter int IA_W   = 10,
  parameter int WA_W   = 15,
  parameter int RES_W  = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic [3:0]       predicted_class,
  output logic             layer_sel,
  output logic             mac_clear,
  output logic             mac_en,
  output logic             mac_last,
  input  logic             dp_ready,
  output logic [IA_W-1:0]  in_addr,
  output logic [WA_W-1:0]  w_addr,
  input  logic             res_valid,
  input  logic [RES_W-1:0] res_data,
  output logic             hid_we,
  output logic [5:0]       hid_addr,
  output logic [RES_W-1:0] hid_wdata
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_CLEAR = 3'd1;
  localparam logic [2:0] S_ISSUE = 3'd2;
  localparam logic [2:0] S_WAIT  = 3'd3;
  localparam logic [2:0] S_NEXT  = 3'd4;

  // Last operand index of a neuron and last neuron index of a layer, per layer.
  localparam logic [IA_W-1:0] L1_FAN_LAST = IA_W'(L1_IN - 1);
  localparam logic [IA_W-1:0] L2_FAN_LAST = IA_W'(L1_OUT - 1);
  localparam logic [5:0]      L1_NEU_LAST = 6'(L1_OUT - 1);
  localparam logic [5:0]      L2_NEU_LAST = 6'(L2_OUT - 1);

  logic [2:0]              state_q, state_d;
  logic                    layer_q, layer_d;
  logic [5:0]              neuron_q, neuron_d;
  logic [IA_W-1:0]         in_addr_q, in_addr_d;
  logic [WA_W-1:0]         w_addr_q, w_addr_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic [3:0]              pred_q, pred_d;
  logic signed [RES_W-1:0] best_q, best_d;
  logic [3:0]              idx_q, idx_d;

  logic [IA_W-1:0] fan_last;
  logic [5:0]      neu_last;

  assign fan_last = layer_q ? L2_FAN_LAST : L1_FAN_LAST;
  assign neu_last = layer_q ? L2_NEU_LAST : L1_NEU_LAST;

  assign busy            = busy_q;
  assign done            = done_q;
  assign predicted_class = pred_q;
  assign layer_sel       = layer_q;
  assign in_addr         = in_addr_q;
  assign w_addr          = w_addr_q;
  assign mac_clear       = (state_q == S_CLEAR);
  assign mac_en          = (state_q == S_ISSUE);
  assign mac_last        = mac_en && (in_addr_q == fan_last);
  // Hidden activations are written straight through in the cycle the result arrives.
  assign hid_we          = (state_q == S_WAIT) && res_valid && !layer_q;
  assign hid_addr        = neuron_q;
  assign hid_wdata       = res_data;

  // Next-state logic: FSM, operand counters and the running argmax.
  always_comb begin
    state_d   = state_q;
    layer_d   = layer_q;
    neuron_d  = neuron_q;
    in_addr_d = in_addr_q;
    w_addr_d  = w_addr_q;
    busy_d    = busy_q;
    done_d    = done_q;
    pred_d    = pred_q;
    best_d    = best_q;
    idx_d     = idx_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          done_d    = 1'b0;
          layer_d   = 1'b0;
          neuron_d  = '0;
          in_addr_d = '0;
          w_addr_d  = '0;
          busy_d    = 1'b1;
          state_d   = S_CLEAR;
        end
      end
      S_CLEAR: state_d = S_ISSUE;
      S_ISSUE: begin
        if (dp_ready) begin
          // w_addr runs linearly across the whole layer; only in_addr wraps per neuron.
          w_addr_d = w_addr_q + WA_W'(1);
          if (in_addr_q == fan_last) begin
            in_addr_d = '0;
            state_d   = S_WAIT;
          end else begin
            in_addr_d = in_addr_q + IA_W'(1);
          end
        end
      end
      S_WAIT: begin
        if (res_valid) begin
          // Strict greater-than keeps the lower index on ties.
          if (layer_q && ((neuron_q == 6'd0) || ($signed(res_data) > best_q))) begin
            best_d = $signed(res_data);
            idx_d  = neuron_q[3:0];
          end
          state_d = S_NEXT;
        end
      end
      S_NEXT: begin
        if (neuron_q != neu_last) begin
          neuron_d = neuron_q + 6'd1;
          state_d  = S_CLEAR;
        end else if (!layer_q) begin
          layer_d  = 1'b1;
          neuron_d = '0;
          w_addr_d = '0;
          state_d  = S_CLEAR;
        end else begin
          pred_d  = idx_q;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State registers with synchronous reset that abandons any inference in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      layer_q   <= 1'b0;
      neuron_q  <= '0;
      in_addr_q <= '0;
      w_addr_q  <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      pred_q    <= '0;
      best_q    <= '0;
      idx_q     <= '0;
    end else begin
      state_q   <= state_d;
      layer_q   <= layer_d;
      neuron_q  <= neuron_d;
      in_addr_q <= in_addr_d;
      w_addr_q  <= w_addr_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      pred_q    <= pred_d;
      best_q    <= best_d;
      idx_q     <= idx_d;
    end
  end

endmodule

// File: tb/tb_mnist_layer_sequencer.sv
// Bench for mnist_layer_sequencer: reduced-size instance driven by a datapath model, plus a full-size smoke run.
// Expected transfers, hidden writes, argmax and latency come from plain loops over the layer dimensions.
// Inputs are driven on the falling edge; outputs are sampled 1 time unit later.
module tb_mnist_layer_sequencer;

  localparam int RL1_IN  = 4;
  localparam int RL1_OUT = 3;
  localparam int RL2_OUT = 10;
  localparam int RLAT    = 2;
  localparam int N_XFER  = RL1_IN * RL1_OUT + RL1_OUT * RL2_OUT;
  localparam int NOM_LAT = 1 + RL1_OUT * (RL1_IN + RLAT + 2) + RL2_OUT * (RL1_OUT + RLAT + 2);
  localparam int FULL_LAT = 1 + 32 * (784 + RLAT + 2) + 10 * (32 + RLAT + 2);

  logic        clk = 1'b0;
  logic        rst, start, dp_ready, res_valid;
  logic [15:0] res_data;
  logic        busy, done, layer_sel, mac_clear, mac_en, mac_last, hid_we;
  logic [3:0]  predicted_class;
  logic [9:0]  in_addr;
  logic [14:0] w_addr;
  logic [5:0]  hid_addr;
  logic [15:0] hid_wdata;

  logic        f_rst, f_start, f_dp_ready, f_res_valid;
  logic [15:0] f_res_data;
  logic        f_busy, f_done, f_layer_sel, f_mac_clear, f_mac_en, f_mac_last, f_hid_we;
  logic [3:0]  f_pred;
  logic [9:0]  f_in_addr;
  logic [14:0] f_w_addr;
  logic [5:0]  f_hid_addr;
  logic [15:0] f_hid_wdata;

  always #5 clk = ~clk;

  mnist_layer_sequencer #(.L1_IN(RL1_IN), .L1_OUT(RL1_OUT), .L2_OUT(RL2_OUT)) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
    .predicted_class(predicted_class), .layer_sel(layer_sel), .mac_clear(mac_clear),
    .mac_en(mac_en), .mac_last(mac_last), .dp_ready(dp_ready), .in_addr(in_addr),
    .w_addr(w_addr), .res_valid(res_valid), .res_data(res_data), .hid_we(hid_we),
    .hid_addr(hid_addr), .hid_wdata(hid_wdata)
  );

  mnist_layer_sequencer dut_full (
    .clk(clk), .rst(f_rst), .start(f_start), .busy(f_busy), .done(f_done),
    .predicted_class(f_pred), .layer_sel(f_layer_sel), .mac_clear(f_mac_clear),
    .mac_en(f_mac_en), .mac_last(f_mac_last), .dp_ready(f_dp_ready), .in_addr(f_in_addr),
    .w_addr(f_w_addr), .res_valid(f_res_valid), .res_data(f_res_data), .hid_we(f_hid_we),
    .hid_addr(f_hid_addr), .hid_wdata(f_hid_wdata)
  );

  int checks = 0;
  int errors = 0;

  // Datapath model state and observation logs.
  bit bp_mode, spur_mode;
  int res_cnt, res_k, clears_since, overlap, n_lasts;
  int hidden[RL1_OUT];
  int scores[10];
  int obs_q[$];
  int hid_a[$];
  int hid_d[$];

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int ref_argmax(input int s[10]);
    int b = s[0];
    int k = 0;
    for (int i = 1; i < 10; i++) if (s[i] > b) begin b = s[i]; k = i; end
    return k;
  endfunction

  function automatic logic [15:0] result_for(input int k);
    if (k < RL1_OUT) return 16'(hidden[k]);
    return 16'(scores[k - RL1_OUT]);
  endfunction

  // One clock: drive datapath inputs for the coming edge, then log what the DUT presents.
  task automatic tick();
    bit xfer, lastx;
    @(negedge clk);
    dp_ready  = bp_mode ? 1'($urandom_range(0, 1)) : 1'b1;
    xfer      = mac_en && dp_ready;
    lastx     = xfer && mac_last;
    res_valid = 1'b0;
    res_data  = 16'($urandom_range(0, 65535));
    if (res_cnt > 0) begin
      res_cnt--;
      if (res_cnt == 0) begin
        res_valid = 1'b1;
        res_data  = result_for(res_k);
        res_k++;
      end
    end else if (spur_mode && $urandom_range(0, 3) == 0) begin
      res_valid = 1'b1;
      res_data  = 16'h7FFF;
    end
    if (lastx) res_cnt = RLAT;
    #1;
    if (mac_clear) clears_since++;
    if (mac_clear && mac_en) overlap++;
    if (hid_we) begin
      hid_a.push_back(int'(hid_addr));
      hid_d.push_back(int'($signed(hid_wdata)));
    end
    if (xfer) begin
      obs_q.push_back(int'(layer_sel) * 1000000 + int'(mac_last) * 100000 + int'(in_addr) * 1000 + int'(w_addr));
      if (lastx) begin
        check("clear_per_neuron", clears_since, 1);
        clears_since = 0;
        n_lasts++;
      end
    end
  endtask

  task automatic run_job(input bit bp, input bit spur, input bit mid_start, input bit abort, input int exp_lat);
    int  cyc;
    int  k;
    int  fan, nout;
    int  exp_pred;
    bit  pulsed = 1'b0;
    bp_mode = bp; spur_mode = spur;
    obs_q.delete(); hid_a.delete(); hid_d.delete();
    res_cnt = 0; res_k = 0; clears_since = 0; overlap = 0; n_lasts = 0;
    start = 1'b1;
    tick();
    start = 1'b0;
    cyc = 1;
    check("busy_after_start", int'(busy), 1);
    check("done_cleared", int'(done), 0);
    while (!done && cyc < 5000) begin
      if (mid_start && !pulsed && n_lasts == RL1_OUT + 1) begin
        start = 1'b1;
        pulsed = 1'b1;
      end
      tick();
      start = 1'b0;
      cyc++;
      if (abort && n_lasts == RL1_OUT + 5) begin
        tick();                       // last operand of layer-2 neuron 4 transfers; now waiting
        rst = 1'b1; res_cnt = 0;
        tick();                       // reset taken while waiting for the result
        rst = 1'b0;
        res_valid = 1'b1; res_data = 16'h7FFF;
        #1;
        check("abort_hid_we", int'(hid_we), 0);
        check("abort_busy", int'(busy), 0);
        check("abort_mac_en", int'(mac_en), 0);
        check("abort_layer", int'(layer_sel), 0);
        check("abort_w_addr", int'(w_addr), 0);
        check("abort_hid_addr", int'(hid_addr), 0);
        @(negedge clk);
        res_valid = 1'b0;
        #1;
        check("abort_done", int'(done), 0);
        check("abort_pred", int'(predicted_class), 0);
        check("abort_busy_after_res", int'(busy), 0);
        check("abort_mac_clear", int'(mac_clear), 0);
        return;
      end
    end
    check("done_reached", int'(done), 1);
    if (exp_lat > 0) check("latency", cyc, exp_lat);
    check("busy_at_done", int'(busy), 0);
    check("clear_en_overlap", overlap, 0);
    // Expected operand stream: every neuron walks its fan-in, weights linear within a layer.
    check("xfer_count", obs_q.size(), N_XFER);
    k = 0;
    for (int l = 0; l < 2; l++) begin
      fan  = (l == 0) ? RL1_IN : RL1_OUT;
      nout = (l == 0) ? RL1_OUT : RL2_OUT;
      for (int n = 0; n < nout; n++)
        for (int i = 0; i < fan; i++) begin
          if (k < obs_q.size())
            check("xfer", obs_q[k], l * 1000000 + ((i == fan - 1) ? 100000 : 0) + i * 1000 + n * fan + i);
          k++;
        end
    end
    check("hid_count", hid_a.size(), RL1_OUT);
    for (int i = 0; i < RL1_OUT; i++) if (i < hid_a.size()) begin
      check("hid_addr", hid_a[i], i);
      check("hid_data", hid_d[i], hidden[i]);
    end
    exp_pred = ref_argmax(scores);
    check("pred", int'(predicted_class), exp_pred);
    for (int i = 0; i < 3; i++) tick();
    check("done_held", int'(done), 1);
    check("pred_held", int'(predicted_class), exp_pred);
  endtask

  task automatic fill_hidden();
    for (int i = 0; i < RL1_OUT; i++) hidden[i] = int'($urandom_range(0, 2000)) - 1000;
  endtask

  task automatic full_smoke();
    int  fcyc = 0;
    int  fcnt = 0;
    int  fk = 0;
    int  fhid = 0;
    int  fsc[10];
    logic [15:0] v;
    for (int i = 0; i < 10; i++) fsc[i] = 0;
    f_rst = 1'b0; f_start = 1'b1;
    while (!f_done && fcyc < 30000) begin
      @(negedge clk);
      f_start = 1'b0;
      fcyc++;
      f_res_valid = 1'b0;
      if (fcnt > 0) begin
        fcnt--;
        if (fcnt == 0) begin
          v = 16'($urandom_range(0, 65535));
          f_res_valid = 1'b1;
          f_res_data  = v;
          if (fk >= 32 && fk < 42) fsc[fk - 32] = int'($signed(v));
          fk++;
        end
      end
      if (f_mac_en && f_mac_last) fcnt = RLAT;
      #1;
      if (f_hid_we) fhid++;
    end
    check("full_done", int'(f_done), 1);
    check("full_latency", fcyc, FULL_LAT);
    check("full_hid_count", fhid, 32);
    check("full_pred", int'(f_pred), ref_argmax(fsc));
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; dp_ready = 1'b1; res_valid = 1'b0; res_data = '0;
    f_rst = 1'b1; f_start = 1'b0; f_dp_ready = 1'b1; f_res_valid = 1'b0; f_res_data = '0;
    bp_mode = 1'b0; spur_mode = 1'b0; res_cnt = 0;
    for (int i = 0; i < 10; i++) tick();
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_pred", int'(predicted_class), 0);
    check("rst_mac_en", int'(mac_en), 0);
    check("rst_mac_clear", int'(mac_clear), 0);
    check("rst_mac_last", int'(mac_last), 0);
    check("rst_layer", int'(layer_sel), 0);
    check("rst_in_addr", int'(in_addr), 0);
    check("rst_w_addr", int'(w_addr), 0);
    check("rst_hid_we", int'(hid_we), 0);
    rst = 1'b0;

    // Nominal: tie between classes 2 and 3 must resolve to 2.
    fill_hidden();
    scores = '{5, -3, 9, 9, 0, -7, 1, 2, 3, 4};
    run_job(1'b0, 1'b0, 1'b0, 1'b0, NOM_LAT);
    check("nominal_class", int'(predicted_class), 2);

    // Backpressure with stray res_valid pulses outside the wait window.
    run_job(1'b1, 1'b1, 1'b0, 1'b0, 0);

    // All-negative scores exercise the signed comparison.
    for (int i = 0; i < 10; i++) scores[i] = -100;
    scores[7] = -1;
    fill_hidden();
    run_job(1'b1, 1'b0, 1'b0, 1'b0, 0);

    // Random narrow-range scores to provoke ties.
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 10; i++) scores[i] = int'($urandom_range(0, 8)) - 4;
      fill_hidden();
      run_job(1'b1, 1'b1, 1'b0, 1'b0, 0);
    end

    // Start pulsed mid layer 2 is ignored; a second start after done reruns cleanly.
    run_job(1'b0, 1'b0, 1'b1, 1'b0, NOM_LAT);
    run_job(1'b0, 1'b0, 1'b0, 1'b0, NOM_LAT);

    // Reset while waiting on layer-2 neuron 4, then a fresh inference.
    run_job(1'b0, 1'b0, 1'b0, 1'b1, 0);
    run_job(1'b0, 1'b0, 1'b0, 1'b0, NOM_LAT);

    full_smoke();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
